// File: rtl/dijkstra_engine.sv
`default_nettype none
// =============================================================================
// dijkstra_engine
// Single-source shortest-path engine over a row-major adjacency matrix in memory.
// Revision: 1.0
// =============================================================================
module dijkstra_engine #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 16,
  parameter int MADDR_WIDTH = 32,
  parameter int MDATA_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH:0]   number_of_nodes,
  input  logic [INDEX_WIDTH-1:0] source_node,
  input  logic [INDEX_WIDTH-1:0] target_node,
  input  logic                   target_enable,
  input  logic [MADDR_WIDTH-1:0] base_address,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   mem_read_enable,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic                   mem_read_ready,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [VALUE_WIDTH-1:0] rd_distance,
  output logic [INDEX_WIDTH-1:0] rd_prev,
  output logic                   rd_reachable
);

  localparam int                     C_NW      = INDEX_WIDTH + 1;
  localparam logic [VALUE_WIDTH-1:0] C_INF     = '1;
  localparam logic [INDEX_WIDTH-1:0] C_NO_PREV = '1;
  localparam logic [INDEX_WIDTH:0]   C_MAX_N   = C_NW'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SELECT = 3'd2,
    S_FETCH  = 3'd3,
    S_WAIT   = 3'd4,
    S_RELAX  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH:0]   n_q, n_d, to_q, to_d, scan_q, scan_d;
  logic [INDEX_WIDTH-1:0] src_q, src_d, tgt_q, tgt_d, cur_q, cur_d, best_idx_q, best_idx_d;
  logic                   tgt_en_q, tgt_en_d, found_q, found_d;
  logic                   busy_q, busy_d, done_q, done_d, error_q, error_d, mem_en_q, mem_en_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d, mem_addr_q, mem_addr_d;
  logic [VALUE_WIDTH-1:0] best_q, best_d, data_q, data_d;
  logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_d [MAX_NODES];
  logic [MAX_NODES-1:0]   visited_q, visited_d;

  logic [INDEX_WIDTH-1:0] w_scan_idx, w_sel_idx, w_to_idx;
  logic [INDEX_WIDTH:0]   w_scan_next, w_to_next;
  logic [VALUE_WIDTH-1:0] w_sel_dist;
  logic [VALUE_WIDTH:0]   w_alt;
  logic [MADDR_WIDTH-1:0] w_req_addr;
  logic                   w_take, w_sel_found, w_scan_last, w_relax, w_cfg_bad, w_skip;
  logic                   w_unused_data;

  // Running minimum over the scan; strict compare keeps the lowest index on ties
  // and never selects an INF node, so "not found" covers both stop conditions.
  assign w_scan_idx  = scan_q[INDEX_WIDTH-1:0];
  assign w_take      = !visited_q[w_scan_idx] && (dist_q[w_scan_idx] < best_q);
  assign w_sel_dist  = w_take ? dist_q[w_scan_idx] : best_q;
  assign w_sel_idx   = w_take ? w_scan_idx : best_idx_q;
  assign w_sel_found = w_take | found_q;
  assign w_scan_next = scan_q + 1'b1;
  assign w_scan_last = (w_scan_next == n_q);

  assign w_to_idx    = to_q[INDEX_WIDTH-1:0];
  assign w_to_next   = to_q + 1'b1;
  assign w_skip      = (w_to_idx == cur_q) || visited_q[w_to_idx];
  assign w_req_addr  = base_q + MADDR_WIDTH'(cur_q) * MADDR_WIDTH'(n_q) + MADDR_WIDTH'(to_q);
  // One extra bit on the sum so saturation is detected instead of wrapping.
  assign w_alt       = {1'b0, dist_q[cur_q]} + {1'b0, data_q};
  assign w_relax     = (data_q != C_INF) && (w_alt < {1'b0, C_INF}) &&
                       (w_alt[VALUE_WIDTH-1:0] < dist_q[w_to_idx]);
  assign w_cfg_bad   = (n_q == '0) || (n_q > C_MAX_N) || ({1'b0, src_q} >= n_q);
  assign w_unused_data = ^mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH];

  always_comb begin
    logic go_select;
    logic go_done;
    go_select  = 1'b0;
    go_done    = 1'b0;
    state_d    = state_q;
    n_d        = n_q;
    src_d      = src_q;
    tgt_d      = tgt_q;
    tgt_en_d   = tgt_en_q;
    base_d     = base_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    cur_d      = cur_q;
    to_d       = to_q;
    scan_d     = scan_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    found_d    = found_q;
    data_d     = data_q;
    dist_d     = dist_q;
    prev_d     = prev_q;
    visited_d  = visited_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d      = number_of_nodes;
          src_d    = source_node;
          tgt_d    = target_node;
          tgt_en_d = target_enable;
          base_d   = base_address;
          done_d   = 1'b0;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        if (w_cfg_bad) begin
          error_d = 1'b1;
          go_done = 1'b1;
        end else begin
          for (int i = 0; i < MAX_NODES; i++) begin
            dist_d[i] = C_INF;
            prev_d[i] = C_NO_PREV;
          end
          visited_d     = '0;
          dist_d[src_q] = '0;
          go_select     = 1'b1;
        end
      end
      S_SELECT: begin
        if (!w_scan_last) begin
          scan_d     = w_scan_next;
          best_d     = w_sel_dist;
          best_idx_d = w_sel_idx;
          found_d    = w_sel_found;
        end else if (!w_sel_found) begin
          go_done = 1'b1;
        end else begin
          visited_d[w_sel_idx] = 1'b1;
          cur_d                = w_sel_idx;
          if (tgt_en_q && (w_sel_idx == tgt_q)) begin
            go_done = 1'b1;
          end else begin
            to_d    = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (w_skip) begin
          to_d = w_to_next;
          if (w_to_next == n_q) go_select = 1'b1;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = w_req_addr;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_read_ready) begin
          data_d   = mem_read_data[VALUE_WIDTH-1:0];
          mem_en_d = 1'b0;
          state_d  = S_RELAX;
        end
      end
      S_RELAX: begin
        if (w_relax) begin
          dist_d[w_to_idx] = w_alt[VALUE_WIDTH-1:0];
          prev_d[w_to_idx] = cur_q;
        end
        to_d = w_to_next;
        if (w_to_next == n_q) go_select = 1'b1;
        else state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_select) begin
      state_d    = S_SELECT;
      scan_d     = '0;
      best_d     = C_INF;
      best_idx_d = '0;
      found_d    = 1'b0;
    end
    if (go_done) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      src_q      <= '0;
      tgt_q      <= '0;
      tgt_en_q   <= 1'b0;
      base_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      cur_q      <= '0;
      to_q       <= '0;
      scan_q     <= '0;
      best_q     <= C_INF;
      best_idx_q <= '0;
      found_q    <= 1'b0;
      data_q     <= '0;
      visited_q  <= '0;
      for (int i = 0; i < MAX_NODES; i++) begin
        dist_q[i] <= C_INF;
        prev_q[i] <= C_NO_PREV;
      end
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      src_q      <= src_d;
      tgt_q      <= tgt_d;
      tgt_en_q   <= tgt_en_d;
      base_q     <= base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      cur_q      <= cur_d;
      to_q       <= to_d;
      scan_q     <= scan_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      found_q    <= found_d;
      data_q     <= data_d;
      visited_q  <= visited_d;
      dist_q     <= dist_d;
      prev_q     <= prev_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign mem_read_enable = mem_en_q;
  assign mem_addr        = mem_addr_q;
  assign rd_distance     = dist_q[rd_index];
  assign rd_prev         = prev_q[rd_index];
  assign rd_reachable    = (dist_q[rd_index] != C_INF);

endmodule
`default_nettype wire
